// File: rtl/fp_acc_dump_if.sv
// ---------------------------------------------------------------------------
// fp_acc_dump_if
// Streaming bus for the integrate-and-dump accumulator.
//   Input side : i_data, i_valid (source -> block), o_ready (block -> source)
//   Output side: o_data, o_valid (block -> sink),  i_ready (sink -> block)
//   o_sat      : result was clamped (present only with FP_ACC_SAT_FLAG_EN)
//   dbg_count  : current frame position (FSM state), for observation only
// Handshake: a beat transfers on a rising clock edge where valid & ready are
// both high. A source holds data/valid stable while ready is low; the block
// holds o_data/o_valid stable until i_ready takes it.
// Optional feature macro: FP_ACC_SAT_FLAG_EN
// ---------------------------------------------------------------------------
interface fp_acc_dump_if #(
  parameter int NB_IN  = 11,
  parameter int NB_OUT = 11,
  parameter int N_ACC  = 8
);
  localparam int CW = $clog2(N_ACC);

  logic [NB_IN-1:0]  i_data;
  logic              i_valid;
  logic              o_ready;
  logic [NB_OUT-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
`ifdef FP_ACC_SAT_FLAG_EN
  logic              o_sat;
`endif
  logic [CW-1:0]     dbg_count;

  // Block-side view
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid,
`ifdef FP_ACC_SAT_FLAG_EN
    output o_sat,
`endif
    output dbg_count
  );

  // Environment-side view (source and sink)
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid,
`ifdef FP_ACC_SAT_FLAG_EN
    input  o_sat,
`endif
    input  dbg_count
  );
endinterface

// File: rtl/fp_acc_dump.sv
// ---------------------------------------------------------------------------
// fp_acc_dump
// Integrate-and-dump accumulator for signed fixed-point samples
// S(NB_IN,NBF_IN). Sums N_ACC samples at full resolution, then emits one
// rounded (half up) and saturated S(NB_OUT,NBF_OUT) result.
// Ports:
//   i_clock  : rising-edge clock
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : synchronous abort, drops the frame and the pending result
//   bus      : fp_acc_dump_if.slave (sample input, result output, debug)
// Optional feature macro: FP_ACC_SAT_FLAG_EN adds the registered o_sat flag.
// Assumes NBF_OUT <= NBF_IN and NB_OUT <= NB_IN + $clog2(N_ACC).
// ---------------------------------------------------------------------------
module fp_acc_dump #(
  parameter int NB_IN   = 11,
  parameter int NBF_IN  = 10,
  parameter int N_ACC   = 8,
  parameter int NB_OUT  = 11,
  parameter int NBF_OUT = 10
) (
  input  logic         i_clock,
  input  logic         i_rst_n,
  input  logic         i_clear,
  fp_acc_dump_if.slave bus
);
  localparam int CW     = $clog2(N_ACC);
  localparam int NB_ACC = NB_IN + CW;
  localparam int D      = NBF_IN - NBF_OUT;
  localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);

  logic [CW-1:0]            count_q, count_d;
  logic signed [NB_ACC-1:0] acc_q;
  logic signed [NB_ACC-1:0] sum_full;
  logic signed [NB_ACC:0]   sum_ext;
  logic signed [NB_ACC:0]   sum_rnd;
  logic [NB_ACC:NB_OUT-1]   upper;
  logic                     sat_hit;
  logic [NB_OUT-1:0]        sat_val;
  logic [NB_OUT-1:0]        o_data_q;
  logic                     o_valid_q;
  logic                     last, ready, accept, take;

  assign accept = bus.i_valid & ready;
  assign take   = o_valid_q & bus.i_ready;

  // ---------------- FSM: state register (state = frame position) ----------
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // ---------------- FSM: next state ---------------------------------------
  always_comb begin
    count_d = count_q;
    if (i_clear)     count_d = '0;
    else if (accept) count_d = last ? '0 : count_q + CW'(1);
  end

  // ---------------- FSM: outputs ------------------------------------------
  // Only the closing sample of a frame can stall: it would overwrite a
  // result that the sink has not yet taken.
  always_comb begin
    last  = (count_q == LAST);
    ready = ~(last & o_valid_q & ~bus.i_ready);
  end

  // ---------------- Datapath ----------------------------------------------
  // NB_ACC bits hold any sum of N_ACC samples, so no overflow is possible.
  assign sum_full = acc_q + {{CW{bus.i_data[NB_IN-1]}}, bus.i_data};
  assign sum_ext  = {sum_full[NB_ACC-1], sum_full};

  generate
    if (D > 0) begin : g_round
      localparam logic signed [NB_ACC:0] HALF = (NB_ACC+1)'(1) << (D - 1);
      assign sum_rnd = (sum_ext + HALF) >>> D;
    end else begin : g_pass
      assign sum_rnd = sum_ext;
    end
  endgenerate

  // Saturate when the bits above the output sign bit disagree with it.
  assign upper   = sum_rnd[NB_ACC:NB_OUT-1];
  assign sat_hit = ~((&upper) | ~(|upper));
  assign sat_val = sat_hit ? (sum_rnd[NB_ACC] ? {1'b1, {(NB_OUT-1){1'b0}}}
                                              : {1'b0, {(NB_OUT-1){1'b1}}})
                           : sum_rnd[NB_OUT-1:0];

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
    end else if (i_clear) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= last ? '0 : sum_full;
    end
  end

  // A dump in the same cycle as a take reloads the register; o_valid stays 1.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else if (i_clear) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else if (accept && last) begin
      o_data_q  <= sat_val;
      o_valid_q <= 1'b1;
    end else if (take) begin
      o_valid_q <= 1'b0;
    end
  end

`ifdef FP_ACC_SAT_FLAG_EN
  logic o_sat_q;
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n)              o_sat_q <= 1'b0;
    else if (i_clear)          o_sat_q <= 1'b0;
    else if (accept && last)   o_sat_q <= sat_hit;
  end
  assign bus.o_sat = o_sat_q;
`endif

  assign bus.o_ready   = ready;
  assign bus.o_data    = o_data_q;
  assign bus.o_valid   = o_valid_q;
  assign bus.dbg_count = count_q;
endmodule
